prio_tag_merge: RTL and testbench

//  Transmit side of the tagged-priority stream. Merges a high-priority (HP) and a normal-priority (NP)

---
 rtl/prio_pkg.sv | 19 +
 rtl/prio_arbiter.sv | 53 +++++
 rtl/prio_tag_merge.sv | 104 ++++++++++
 tb/tb_prio_tag_merge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared types and constants for the tagged-priority merge
package prio_pkg;

    // Number of words currently held in the main/skid output pair
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slot_state_t;

    localparam logic TAG_HP = 1'b1;
    localparam logic TAG_NP = 1'b0;

    // Bit index of the priority tag inside a dw-bit output word
    function automatic int prio_tag(input int dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - strict HP preference with bounded NP starvation
module prio_arbiter
    import prio_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hp_vld,
    input  logic np_vld,
    input  logic space,
    input  logic accept,
    output logic grant_hp,
    output logic grant_np
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    generate
        if (MAX_BURST < 1) begin : g_bad_burst
            $error("prio_arbiter: MAX_BURST must be at least 1");
        end
    endgenerate

    logic [CW-1:0] burst_cnt;
    logic          acc_q;

    // An accept only happens with space available; qualifying keeps the count frozen when full
    assign acc_q = accept & space;

    // HP wins unless NP is waiting and HP has already used its burst allowance
    always_comb begin
        grant_hp = hp_vld & (~np_vld | (burst_cnt < BURST_MAX));
        grant_np = np_vld & ~grant_hp;
    end

    // Count consecutive HP wins that made NP wait; any NP win or uncontested HP win clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt <= '0;
        end else if (acc_q) begin
            if (grant_hp && np_vld) begin
                if (burst_cnt < BURST_MAX) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/prio_tag_merge.sv
// rtl/prio_tag_merge.sv - merges HP/NP sources into one tagged stream with 2-entry output buffer
module prio_tag_merge
    import prio_pkg::*;
#(
    parameter int DW        = 33,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-2:0] hp_data_i,
    input  logic          hp_vld_i,
    output logic          hp_rdy_o,
    input  logic [DW-2:0] np_data_i,
    input  logic          np_vld_i,
    output logic          np_rdy_o,
    output logic [DW-1:0] data_out,
    output logic          vld_o,
    input  logic          rdy_i
);

    localparam int TAG = prio_tag(DW);

    slot_state_t   state;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] word;
    logic          space;
    logic          grant_hp;
    logic          grant_np;
    logic          accept;
    logic          take;

    // Space depends only on held state (and reset), so downstream ready never reaches the input readies
    assign space    = rst & (state != TWO);
    assign hp_rdy_o = space & grant_hp;
    assign np_rdy_o = space & grant_np;
    assign accept   = (hp_vld_i & hp_rdy_o) | (np_vld_i & np_rdy_o);
    assign vld_o    = (state != EMPTY);
    assign take     = vld_o & rdy_i;
    assign data_out = main_q;

    prio_arbiter #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .hp_vld   (hp_vld_i),
        .np_vld   (np_vld_i),
        .space    (space),
        .accept   (accept),
        .grant_hp (grant_hp),
        .grant_np (grant_np)
    );

    // Build the tagged word from whichever source holds the grant
    always_comb begin
        word = '0;
        if (grant_hp) begin
            word[TAG]     = TAG_HP;
            word[TAG-1:0] = hp_data_i;
        end else begin
            word[TAG]     = TAG_NP;
            word[TAG-1:0] = np_data_i;
        end
    end

    // Occupancy FSM: main always holds the oldest word, skid the younger one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= word;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !take) begin
                        skid_q <= word;
                        state  <= TWO;
                    end else if (take && !accept) begin
                        state  <= EMPTY;
                    end else if (accept && take) begin
                        main_q <= word;
                    end
                end
                TWO: begin
                    if (take) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_tag_merge.sv
// tb/tb_prio_tag_merge.sv - directed and scoreboarded checks for prio_tag_merge
module tb_prio_tag_merge;

    logic        clk;
    logic        rst;
    logic [31:0] hp_data;
    logic        hp_vld;
    logic        hp_rdy;
    logic [31:0] np_data;
    logic        np_vld;
    logic        np_rdy;
    logic [32:0] data_out;
    logic        vld;
    logic        rdy;

    int n_vec;
    int n_err;

    prio_tag_merge #(
        .DW        (33),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hp_data_i (hp_data),
        .hp_vld_i  (hp_vld),
        .hp_rdy_o  (hp_rdy),
        .np_data_i (np_data),
        .np_vld_i  (np_vld),
        .np_rdy_o  (np_rdy),
        .data_out  (data_out),
        .vld_o     (vld),
        .rdy_i     (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] mk(input logic t, input logic [31:0] p);
        return {t, p};
    endfunction

    logic [32:0] q[$];
    int          m_cnt;
    logic        e_ghp, e_gnp, e_sp, e_acc, e_tk;
    logic        t_seq [0:4];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        hp_vld  = 1'b1;
        np_vld  = 1'b0;
        hp_data = 32'h0;
        np_data = 32'h0;
        rdy     = 1'b0;
        #2;
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_hp_rdy", 64'(hp_rdy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        hp_vld = 1'b0;

        // Test 1: two words held, async reset mid-cycle
        hp_vld  = 1'b1;
        hp_data = 32'hA;
        #1;
        chk("t1_hp_rdy_empty", 64'(hp_rdy), 64'd1);
        tick();
        chk("t1_vld_one", 64'(vld), 64'd1);
        chk("t1_data_a", 64'(data_out), 64'(mk(1'b1, 32'hA)));
        hp_data = 32'hB;
        tick();
        chk("t1_hp_rdy_full", 64'(hp_rdy), 64'd0);
        chk("t1_data_hold", 64'(data_out), 64'(mk(1'b1, 32'hA)));
        #2;
        rst = 1'b0;
        #1;
        chk("t1_async_vld", 64'(vld), 64'd0);
        chk("t1_async_data", 64'(data_out), 64'd0);
        chk("t1_async_rdy", 64'(hp_rdy), 64'd0);
        rst     = 1'b1;
        hp_data = 32'h1;
        tick();
        chk("t1_after_rel", 64'(data_out), 64'h1_0000_0001);
        chk("t1_after_vld", 64'(vld), 64'd1);

        // Drain
        hp_vld = 1'b0;
        rdy    = 1'b1;
        tick();
        chk("drain1_vld", 64'(vld), 64'd0);

        // Test 2: HP only, back-to-back, no bubbles
        for (int i = 1; i <= 8; i++) begin
            hp_vld  = 1'b1;
            hp_data = 32'(i);
            #1;
            chk("t2_hp_rdy", 64'(hp_rdy), 64'd1);
            tick();
            chk("t2_vld", 64'(vld), 64'd1);
            chk("t2_data", 64'(data_out), 64'(mk(1'b1, 32'(i))));
        end
        hp_vld = 1'b0;
        tick();
        chk("t2_end_vld", 64'(vld), 64'd0);

        // Test 3: both valid always -> 4 HP then 1 NP, repeating
        hp_vld = 1'b1;
        np_vld = 1'b1;
        for (int k = 0; k < 10; k++) begin
            hp_data = 32'h100 + 32'(k);
            np_data = 32'h200 + 32'(k);
            #1;
            chk("t3_np_rdy", 64'(np_rdy), 64'((k % 5) == 4));
            tick();
            if ((k % 5) == 4)
                chk("t3_word", 64'(data_out), 64'(mk(1'b0, 32'h200 + 32'(k))));
            else
                chk("t3_word", 64'(data_out), 64'(mk(1'b1, 32'h100 + 32'(k))));
        end
        hp_vld = 1'b0;
        np_vld = 1'b0;
        tick();
        chk("t3_end_vld", 64'(vld), 64'd0);

        // Test 4: backpressure with NP A,B,C
        rdy     = 1'b0;
        np_vld  = 1'b1;
        np_data = 32'hA;
        #1;
        chk("t4_rdy_a", 64'(np_rdy), 64'd1);
        tick();
        np_data = 32'hB;
        #1;
        chk("t4_rdy_b", 64'(np_rdy), 64'd1);
        tick();
        np_data = 32'hC;
        #1;
        chk("t4_rdy_c_blk", 64'(np_rdy), 64'd0);
        tick();
        chk("t4_hold_a", 64'(data_out), 64'(mk(1'b0, 32'hA)));
        chk("t4_still_blk", 64'(np_rdy), 64'd0);
        rdy = 1'b1;
        #1;
        chk("t4_no_comb_path", 64'(np_rdy), 64'd0);
        tick();
        chk("t4_out_b", 64'(data_out), 64'(mk(1'b0, 32'hB)));
        chk("t4_rdy_c", 64'(np_rdy), 64'd1);
        tick();
        chk("t4_out_c", 64'(data_out), 64'(mk(1'b0, 32'hC)));
        np_vld = 1'b0;
        tick();
        chk("t4_end_vld", 64'(vld), 64'd0);

        // Test 5: NP withdraws after 2 HP grants, burst count restarts
        hp_vld  = 1'b1;
        np_vld  = 1'b1;
        hp_data = 32'h51;
        tick();
        chk("t5_pre1", 64'(data_out), 64'(mk(1'b1, 32'h51)));
        hp_data = 32'h52;
        tick();
        chk("t5_pre2", 64'(data_out), 64'(mk(1'b1, 32'h52)));
        np_vld  = 1'b0;
        hp_data = 32'h53;
        tick();
        chk("t5_solo", 64'(data_out), 64'(mk(1'b1, 32'h53)));
        np_vld  = 1'b1;
        np_data = 32'h5F;
        t_seq   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            hp_data = 32'h60 + 32'(k);
            tick();
            chk("t5_tag", 64'(data_out[32]), 64'(t_seq[k]));
        end
        hp_vld = 1'b0;
        np_vld = 1'b0;
        tick();
        chk("t5_end_vld", 64'(vld), 64'd0);

        // Test 6: random valids/ready against a scoreboard and reference arbiter
        m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            hp_vld  = 1'($urandom_range(0, 1));
            np_vld  = 1'($urandom_range(0, 1));
            hp_data = $urandom;
            np_data = $urandom;
            rdy     = ($urandom_range(0, 9) < 6);
            #1;
            e_sp  = (q.size() < 2);
            e_ghp = hp_vld && (!np_vld || m_cnt < 4);
            e_gnp = np_vld && !e_ghp;
            chk("rnd_hp_rdy", 64'(hp_rdy), 64'(e_sp && e_ghp));
            chk("rnd_np_rdy", 64'(np_rdy), 64'(e_sp && e_gnp));
            chk("rnd_vld", 64'(vld), 64'(q.size() != 0));
            if (q.size() != 0)
                chk("rnd_data", 64'(data_out), 64'(q[0]));
            e_acc = e_sp && (e_ghp || e_gnp);
            e_tk  = (q.size() != 0) && rdy;
            if (e_tk)
                void'(q.pop_front());
            if (e_acc) begin
                q.push_back(e_ghp ? mk(1'b1, hp_data) : mk(1'b0, np_data));
                if (e_ghp && np_vld)
                    m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
                else
                    m_cnt = 0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
